// File: rtl/board_pkg.sv
// Shared board geometry, tile/board types and the copy FSM state encoding
// used by the demux/store block and its bench.
package board_pkg;

  localparam int N = 4;
  localparam int W = 12;

  typedef logic [W-1:0] tile_t;
  typedef tile_t [N-1:0][N-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DONE
  } state_t;

endpackage

// File: rtl/board_demux_store_tile_counter.sv
// Row-major tile index counter: cleared on copy accept, advances while enabled
// and wraps to zero after the last tile.
module tile_counter #(
  parameter int unsigned LAST = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       wrap_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  assign wrap_o = en_i && (count_q == 4'(LAST));

  // NOTE: count_d takes a default before any branch so no path infers a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i || wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/board_demux_store.sv
// Copies an N x N board into one of two register banks, one tile per cycle,
// or zeroes a selected bank in a single cycle.
module board_demux_store
  import board_pkg::*;
#(
  parameter int N = board_pkg::N,
  parameter int W = board_pkg::W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sel,
  input  logic                         clear,
  input  logic [N-1:0][N-1:0][W-1:0]   M_in,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   idx,
  output logic [N-1:0][N-1:0][W-1:0]   OM0,
  output logic [N-1:0][N-1:0][W-1:0]   OM1
);

  localparam int unsigned LAST = N * N - 1;

  state_t                       state_q;
  logic                         bank_q;
  logic                         busy_q;
  logic                         done_q;
  logic [N-1:0][N-1:0][W-1:0]   om0_q;
  logic [N-1:0][N-1:0][W-1:0]   om1_q;
  logic [3:0]                   idx_q;
  logic                         last_tile;
  logic                         accept;
  logic                         clear_req;
  logic                         copy_en;

  // start has priority over clear; neither is looked at outside IDLE.
  assign accept    = (state_q == IDLE) && start;
  assign clear_req = (state_q == IDLE) && clear && !start;
  assign copy_en   = (state_q == COPY);

  tile_counter #(
    .LAST (LAST)
  ) u_tile_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept),
    .en_i    (copy_en),
    .count_o (idx_q),
    .wrap_o  (last_tile)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bank_q  <= sel;
            busy_q  <= 1'b1;
            state_q <= COPY;
          end
        end
        COPY: begin
          if (last_tile) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // NOTE: the banks are plain flops, not RAM, so they can and must be reset;
  // an aborted copy leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      om0_q <= '0;
      om1_q <= '0;
    end else if (clear_req) begin
      if (sel) begin
        om1_q <= '0;
      end else begin
        om0_q <= '0;
      end
    end else if (copy_en) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (idx_q == 4'(r * N + c)) begin
            if (bank_q) begin
              om1_q[r][c] <= M_in[r][c];
            end else begin
              om0_q[r][c] <= M_in[r][c];
            end
          end
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign idx  = idx_q;
  assign OM0  = om0_q;
  assign OM1  = om1_q;

endmodule

// File: tb/tb_board_demux_store.sv
// Scoreboard bench for board_demux_store: each accepted copy pushes its
// expected bank image, which is popped and compared when done pulses.
module tb_board_demux_store;
  import board_pkg::*;

  typedef struct {
    bit     bank;
    board_t data;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   start = 1'b0;
  logic   sel = 1'b0;
  logic   clear = 1'b0;
  board_t M_in = '0;
  logic   busy;
  logic   done;
  logic [3:0] idx;
  board_t OM0;
  board_t OM1;

  board_t m0 = '0;
  board_t m1 = '0;
  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;

  board_demux_store dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sel   (sel),
    .clear (clear),
    .M_in  (M_in),
    .busy  (busy),
    .done  (done),
    .idx   (idx),
    .OM0   (OM0),
    .OM1   (OM1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one copy and follow it to completion. with_clear raises clear
  // alongside start; inject fires a competing start/clear/sel-flip mid-copy.
  task automatic run_copy(input string name, input bit bank, input board_t data,
                          input bit with_clear, input bit inject);
    int   busy_cnt = 0;
    bit   seen = 0;
    bit   pending = inject;
    exp_t e;
    M_in  = data;
    sel   = bank;
    start = 1'b1;
    clear = with_clear;
    sb_q.push_back('{bank, data});
    tick();
    start = 1'b0;
    clear = 1'b0;
    checks++;
    if (busy !== 1'b1 || idx !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b idx=%0d done=%b, need busy=1 idx=0 done=0",
               name, busy, idx, done);
    end
    checks++;
    if (OM0 !== m0 || OM1 !== m1) begin
      errors++;
      $display("FAIL %s banks_at_accept: OM0=%h OM1=%h, need OM0=%h OM1=%h",
               name, OM0, OM1, m0, m1);
    end
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL %s busy_done_overlap at cycle %0d", name, cyc);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        seen = 1;
      end else if (pending && idx == 4'd6) begin
        // tiles 0..5 are visible already, tile 15 still holds the old value
        checks++;
        if ((bank ? OM1[1][1] : OM0[1][1]) !== data[1][1] ||
            (bank ? OM1[3][3] : OM0[3][3]) !== (bank ? m1[3][3] : m0[3][3])) begin
          errors++;
          $display("FAIL %s partial_write: t5=%h t15=%h, need t5=%h t15=%h", name,
                   bank ? OM1[1][1] : OM0[1][1], bank ? OM1[3][3] : OM0[3][3],
                   data[1][1], bank ? m1[3][3] : m0[3][3]);
        end
        sel   = ~bank;
        start = 1'b1;
        clear = 1'b1;
        tick();
        start   = 1'b0;
        clear   = 1'b0;
        pending = 0;
      end else begin
        tick();
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done within 40 cycles", name);
    end
    checks++;
    if (busy_cnt != 16) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, need 16", name, busy_cnt);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.bank) m1 = e.data;
      else        m0 = e.data;
    end
    checks++;
    if (OM0 !== m0) begin
      errors++;
      $display("FAIL %s OM0: got %h, need %h", name, OM0, m0);
    end
    checks++;
    if (OM1 !== m1) begin
      errors++;
      $display("FAIL %s OM1: got %h, need %h", name, OM1, m1);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || idx !== 4'd0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b idx=%0d, need 0 0 0",
               name, done, busy, idx);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || idx !== 4'd0 || OM0 !== '0 || OM1 !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b idx=%0d OM0=%h OM1=%h, need all 0",
               busy, done, idx, OM0, OM1);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_copy_bank0();
    board_t b;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        b[i][j] = W'(16 * i + j);
    run_copy("copy_bank0", 1'b0, b, 1'b0, 1'b0);
  endtask

  task automatic test_copy_bank1();
    board_t b;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        b[i][j] = 12'h800;
    run_copy("copy_bank1", 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic test_midcopy_requests();
    board_t b;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        b[i][j] = W'($urandom);
    run_copy("midcopy", 1'b0, b, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || OM0 !== m0 || OM1 !== m1) begin
        errors++;
        $display("FAIL midcopy_dropped[%0d]: busy=%b done=%b, need idle and unchanged banks",
                 k, busy, done);
      end
      tick();
    end
  endtask

  task automatic test_clear();
    sel   = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m1 = '0;
    checks++;
    if (OM1 !== m1 || OM0 !== m0) begin
      errors++;
      $display("FAIL clear_bank1: OM0=%h OM1=%h, need OM0=%h OM1=%h", OM0, OM1, m0, m1);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_flags: done=%b busy=%b, need 0 0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_done: done=%b, need 0", done);
    end
  endtask

  task automatic test_start_and_clear();
    board_t full;
    board_t b;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        full[i][j] = 12'h800;
        b[i][j]    = W'($urandom);
      end
    run_copy("refill_bank1", 1'b1, full, 1'b0, 1'b0);
    run_copy("start_and_clear", 1'b1, b, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    board_t b;
    bit found = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        b[i][j] = W'($urandom) | 12'h001;
    M_in  = b;
    sel   = 1'b1;
    start = 1'b1;
    sb_q.push_back('{1'b1, b});
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      if (idx == 4'd9) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL areset_reach_idx9: idx=%0d, need 9 within 20 cycles", idx);
    end
    #2 rst = 1'b1;
    #1;
    sb_q.delete();
    m0 = '0;
    m1 = '0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || idx !== 4'd0 || OM0 !== '0 || OM1 !== '0) begin
      errors++;
      $display("FAIL areset_immediate: busy=%b done=%b idx=%0d OM0=%h OM1=%h, need all 0",
               busy, done, idx, OM0, OM1);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || OM1 !== '0) begin
        errors++;
        $display("FAIL areset_no_resume[%0d]: done=%b busy=%b OM1=%h, need 0 0 0",
                 k, done, busy, OM1);
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        b[i][j] = W'(i * 256 + j * 3 + 7);
    run_copy("after_areset", 1'b0, b, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_copy_bank0();
    test_copy_bank1();
    test_midcopy_requests();
    test_clear();
    test_start_and_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_demux_store.md
BOARD_DEMUX_STORE -- requirements
Module: board_demux_store

Interface
REQ-001 Parameter N, default 4, board dimension (rows = columns).
REQ-002 Parameter W, default 12, tile value width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request to copy M_in into the bank chosen by sel; sampled only in IDLE.
REQ-006 sel  input  1  bank select: 0 = bank 0 (OM0), 1 = bank 1 (OM1); sampled with start or clear.
REQ-007 clear  input  1  request to zero the bank chosen by sel; sampled only in IDLE.
REQ-008 M_in  input  W x [N][N]  source board; caller holds it stable while busy = 1.
REQ-009 busy  output  1  high while in COPY.
REQ-010 done  output  1  one-cycle pulse after the last tile is written.
REQ-011 idx  output  4  tile index being written (row-major, idx = row*N + col).
REQ-012 OM0  output  W x [N][N]  bank 0 contents, driven directly from registers.
REQ-013 OM1  output  W x [N][N]  bank 1 contents, driven directly from registers.

Function
REQ-014 The FSM SHALL have three states: IDLE, COPY, DONE.
REQ-015 In IDLE with start = 1: latch sel into bank_q, set idx = 0, go to COPY.
REQ-016 In COPY, each rising edge SHALL write M_in[idx/N][idx%N] into tile [idx/N][idx%N] of bank bank_q and increment idx.
REQ-017 In COPY with idx = N*N-1: write that last tile, go to DONE, and wrap idx to 0.
REQ-018 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-019 Latency: start sampled at edge E0; tiles written at edges E1..E16; done high between E16 and E17; busy high between E0 and E16.
REQ-020 The unselected bank SHALL never change during a copy.
REQ-021 In IDLE with clear = 1 and start = 0: zero every tile of the bank chosen by sel at the next edge; stay in IDLE; no done pulse.
REQ-022 start and clear both high in IDLE: start SHALL win; clear SHALL be ignored.
REQ-023 start or clear while in COPY or DONE SHALL be ignored; no queuing.
REQ-024 sel changes during COPY SHALL have no effect; bank_q governs.
REQ-025 busy and done SHALL never be high in the same cycle.
REQ-026 Outputs OM0/OM1 SHALL show each written tile from the edge it is written (no end-of-copy commit).

Reset
REQ-027 rst high SHALL force, asynchronously: state = IDLE, idx = 0, bank_q = 0, busy = 0, done = 0, all tiles of OM0 and OM1 = 0.
REQ-028 rst during COPY SHALL abort the copy; partially written tiles are lost (zeroed); no done pulse.
REQ-029 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-030 A shared package board_pkg SHALL hold N, W, tile_t (logic [W-1:0]), board_t (tile_t [N][N]) and the state enum {IDLE, COPY, DONE}.
REQ-031 The 4-bit tile index counter (reset, enable, wrap at N*N-1) SHALL be a sub-module named tile_counter; everything else stays in board_demux_store.

Verification
REQ-032 Reset, then start with sel = 0 and M_in[i][j] = 16*i+j -> OM0 matches M_in after E16; OM1 stays all 0; done is high for exactly one cycle; busy is high for 16 cycles.
REQ-033 Preload bank 0 as in REQ-032, then start with sel = 1 and all tiles 12'h800 -> OM1 is all 12'h800; OM0 is unchanged.
REQ-034 Mid-copy (after the edge with idx = 5), toggle sel and pulse start and clear -> copy completes into the original bank, done pulses once, the extra requests are dropped.
REQ-035 clear = 1 with sel = 1 and bank 1 full -> OM1 is all 0 one edge later; done stays 0; with start = 1 and clear = 1 together, the copy occurs and no clear occurs.
REQ-036 Assert rst asynchronously (between edges) when idx = 9 -> all outputs are 0 immediately; state is IDLE; no done pulse; a new start then completes normally.
